// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder.
package serial_adder_pkg;

    // Controller states; encodings are fixed so traces read the same across builds.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the digit counter: clog2(ndig), never less than one bit.
    function automatic int cnt_width(input int ndig);
        return (ndig <= 1) ? 1 : $clog2(ndig);
    endfunction

endpackage

// File: rtl/digit_adder.sv
// DIGIT-bit ripple-carry slice; also exposes the carry into its top bit so
// the caller can derive signed overflow on the final digit.
module digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    // c[i] is the carry into bit i of the slice.
    logic [DIGIT:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (s[i]),
            .cout (c[i+1])
        );
    end

    assign cout  = c[DIGIT];
    assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell, the building block of the digit slice.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder: computes A + B + Cin over WIDTH/DIGIT cycles with a
// start/busy/done handshake, registered carry and signed-overflow flag.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             ovf
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = cnt_width(NDIG);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh, b_sh, psum;
    logic [WIDTH-1:0] psum_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             last_digit;

    logic [DIGIT-1:0] d_sum;
    logic             d_cout, d_cmsb;

    // Combinational digit slice fed by the low digit of each operand register.
    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .a     (a_sh[DIGIT-1:0]),
        .b     (b_sh[DIGIT-1:0]),
        .cin   (carry),
        .s     (d_sum),
        .cout  (d_cout),
        .c_msb (d_cmsb)
    );

    // New digit enters at the top so after NDIG shifts the sum is aligned at bit 0.
    assign psum_next  = (psum >> DIGIT) | (WIDTH'(d_sum) << (WIDTH - DIGIT));
    assign last_digit = (cnt == CW'(NDIG - 1));

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and handshake outputs.
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        busy    = (state_q != IDLE);
        done    = (state_q == DONE);
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_digit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand shifters, carry/count and result registers; results only move
    // on the final digit so they stay stable for the whole RUN phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            psum  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            S     <= '0;
            Cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sh  <= A;
                        b_sh  <= B;
                        psum  <= '0;
                        carry <= Cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> DIGIT;
                    b_sh  <= b_sh >> DIGIT;
                    psum  <= psum_next;
                    carry <= d_cout;
                    cnt   <= cnt + CW'(1);
                    if (last_digit) begin
                        S    <= psum_next;
                        Cout <= d_cout;
                        ovf  <= d_cout ^ d_cmsb;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: five instances with different
// WIDTH/DIGIT, directed vectors, handshake corner cases, random and
// exhaustive sweeps against an arithmetic reference model.
module tb_serial_adder;

    localparam int NDUT = 5;
    localparam int W_TAB [NDUT] = '{8, 8, 4, 4, 4};
    localparam int D_TAB [NDUT] = '{1, 4, 1, 2, 4};

    logic       clk;
    logic       rst;
    logic       start_v [NDUT];
    logic [7:0] a_v     [NDUT];
    logic [7:0] b_v     [NDUT];
    logic       cin_v   [NDUT];
    logic       busy_v  [NDUT];
    logic       done_v  [NDUT];
    logic [7:0] s_v     [NDUT];
    logic       cout_v  [NDUT];
    logic       ovf_v   [NDUT];

    // Expected held value of S per instance (previous result, 0 after reset).
    logic [7:0] last_s  [NDUT];

    int n_cmp = 0;
    int n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int W = W_TAB[g];
        localparam int D = D_TAB[g];
        logic [W-1:0] s_l;
        logic         busy_l, done_l, cout_l, ovf_l;

        serial_adder #(.WIDTH(W), .DIGIT(D)) u_dut (
            .clk   (clk),
            .rst   (rst),
            .start (start_v[g]),
            .A     (a_v[g][W-1:0]),
            .B     (b_v[g][W-1:0]),
            .Cin   (cin_v[g]),
            .busy  (busy_l),
            .done  (done_l),
            .S     (s_l),
            .Cout  (cout_l),
            .ovf   (ovf_l)
        );

        assign busy_v[g] = busy_l;
        assign done_v[g] = done_l;
        assign s_v[g]    = 8'(s_l);
        assign cout_v[g] = cout_l;
        assign ovf_v[g]  = ovf_l;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain unsigned and signed arithmetic on w-bit operands.
    function automatic void ref_add(input int w, input int a, input int b, input int c,
                                    output logic [7:0] s, output logic co, output logic ov);
        int modv, sum, sa, sb, ss;
        modv = 1 << w;
        sum  = a + b + c;
        s    = 8'(sum % modv);
        co   = (sum >= modv);
        sa   = (a >= modv / 2) ? a - modv : a;
        sb   = (b >= modv / 2) ? b - modv : b;
        ss   = sa + sb + c;
        ov   = (ss > modv / 2 - 1) || (ss < -(modv / 2));
    endfunction

    // One full operation on instance idx, starting and ending at a negedge
    // with the instance idle. Checks handshake timing, result hold during RUN
    // and the final result against the supplied expectation.
    task automatic do_op(input string tag, input int idx,
                         input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic [7:0] es, input logic eco, input logic eov);
        int ndig;
        int lat;
        ndig = W_TAB[idx] / D_TAB[idx];
        check({tag, ".idle_before"}, 32'(busy_v[idx]), 32'd0);
        start_v[idx] = 1'b1;
        a_v[idx]     = a;
        b_v[idx]     = b;
        cin_v[idx]   = cin;
        @(negedge clk);
        start_v[idx] = 1'b0;
        a_v[idx]     = 8'($urandom);
        b_v[idx]     = 8'($urandom);
        cin_v[idx]   = 1'($urandom);
        check({tag, ".busy_rise"}, 32'(busy_v[idx]), 32'd1);
        lat = 1;
        while (done_v[idx] !== 1'b1 && lat < 40) begin
            check({tag, ".s_hold"}, 32'(s_v[idx]), 32'(last_s[idx]));
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'(ndig + 1));
        check({tag, ".s"},    32'(s_v[idx]),    32'(es));
        check({tag, ".cout"}, 32'(cout_v[idx]), 32'(eco));
        check({tag, ".ovf"},  32'(ovf_v[idx]),  32'(eov));
        last_s[idx] = es;
        @(negedge clk);
        check({tag, ".done_fall"}, 32'(done_v[idx]), 32'd0);
        check({tag, ".busy_fall"}, 32'(busy_v[idx]), 32'd0);
    endtask

    task automatic model_op(input string tag, input int idx,
                            input logic [7:0] a, input logic [7:0] b, input logic cin);
        logic [7:0] es;
        logic       eco, eov;
        ref_add(W_TAB[idx], int'(a), int'(b), int'(cin), es, eco, eov);
        do_op(tag, idx, a, b, cin, es, eco, eov);
    endtask

    typedef struct {
        int         idx;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       co;
        logic       ov;
    } vec_t;

    vec_t tab [9];

    initial begin
        int  lat;
        bit  saw_done;
        logic [7:0] m;

        tab[0] = '{0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        tab[1] = '{0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        tab[2] = '{0, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        tab[3] = '{1, 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0};
        tab[4] = '{0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        tab[5] = '{1, 8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1};
        tab[6] = '{2, 8'h07, 8'h01, 1'b0, 8'h08, 1'b0, 1'b1};
        tab[7] = '{4, 8'h0F, 8'h0F, 1'b1, 8'h0F, 1'b1, 1'b0};
        tab[8] = '{3, 8'h08, 8'h08, 1'b0, 8'h00, 1'b1, 1'b1};

        rst = 1'b1;
        for (int i = 0; i < NDUT; i++) begin
            start_v[i] = 1'b0;
            a_v[i]     = 8'h00;
            b_v[i]     = 8'h00;
            cin_v[i]   = 1'b0;
            last_s[i]  = 8'h00;
        end
        repeat (3) @(negedge clk);

        // Reset state of every instance.
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("rst%0d.busy", i), 32'(busy_v[i]), 32'd0);
            check($sformatf("rst%0d.done", i), 32'(done_v[i]), 32'd0);
            check($sformatf("rst%0d.s", i),    32'(s_v[i]),    32'd0);
            check($sformatf("rst%0d.cout", i), 32'(cout_v[i]), 32'd0);
            check($sformatf("rst%0d.ovf", i),  32'(ovf_v[i]),  32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors.
        for (int i = 0; i < 9; i++)
            do_op($sformatf("vec%0d", i), tab[i].idx, tab[i].a, tab[i].b, tab[i].cin,
                  tab[i].s, tab[i].co, tab[i].ov);

        // start held high; operands change during RUN and must be ignored.
        // DONE always falls back to IDLE, so the held request is taken on the
        // first edge that sees IDLE, two edges after the result edge.
        start_v[0] = 1'b1;
        a_v[0]     = 8'h10;
        b_v[0]     = 8'h20;
        cin_v[0]   = 1'b0;
        @(negedge clk);
        a_v[0] = 8'hFF;
        b_v[0] = 8'hFF;
        check("held.busy_rise", 32'(busy_v[0]), 32'd1);
        lat = 1;
        while (done_v[0] !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("held.latency", 32'(lat), 32'd9);
        check("held.s",    32'(s_v[0]),    32'h30);
        check("held.cout", 32'(cout_v[0]), 32'd0);
        @(negedge clk);
        check("held.idle_gap", 32'(busy_v[0]), 32'd0);
        @(negedge clk);
        check("held.reaccept", 32'(busy_v[0]), 32'd1);
        start_v[0] = 1'b0;
        last_s[0]  = 8'h30;
        lat = 1;
        while (done_v[0] !== 1'b1 && lat < 40) begin
            check("held2.s_hold", 32'(s_v[0]), 32'(last_s[0]));
            @(negedge clk);
            lat++;
        end
        check("held2.latency", 32'(lat), 32'd9);
        check("held2.s",    32'(s_v[0]),    32'hFE);
        check("held2.cout", 32'(cout_v[0]), 32'd1);
        check("held2.ovf",  32'(ovf_v[0]),  32'd0);
        last_s[0] = 8'hFE;
        @(negedge clk);

        // Reset in the middle of RUN discards the operation.
        start_v[0] = 1'b1;
        a_v[0]     = 8'hFF;
        b_v[0]     = 8'h01;
        cin_v[0]   = 1'b0;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst.busy_pre", 32'(busy_v[0]), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst.busy", 32'(busy_v[0]), 32'd0);
        check("midrst.done", 32'(done_v[0]), 32'd0);
        check("midrst.s",    32'(s_v[0]),    32'd0);
        check("midrst.cout", 32'(cout_v[0]), 32'd0);
        check("midrst.ovf",  32'(ovf_v[0]),  32'd0);
        for (int i = 0; i < NDUT; i++) last_s[i] = 8'h00;
        saw_done = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done_v[0] === 1'b1 || busy_v[0] === 1'b1) saw_done = 1'b1;
        end
        check("midrst.no_done", 32'(saw_done), 32'd0);

        // Random operands on the 8-bit instances.
        for (int n = 0; n < 40; n++) begin
            model_op($sformatf("rnd8x1_%0d", n), 0, 8'($urandom), 8'($urandom), 1'($urandom));
            model_op($sformatf("rnd8x4_%0d", n), 1, 8'($urandom), 8'($urandom), 1'($urandom));
        end

        // Exhaustive 4-bit sweep for DIGIT = 1, 2, 4.
        for (int d = 2; d < NDUT; d++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    for (int c = 0; c < 2; c++) begin
                        m = 8'(a);
                        model_op($sformatf("ex%0d_%0h_%0h_%0d", d, a, b, c), d, m, 8'(b), 1'(c));
                    end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
